// File: rtl/tx_word_scheduler.sv
// Round-robin scheduler sharing one TX word channel among NUM_REQ requesters,
// with a per-grant burst limit and an ack watchdog so a stuck port cannot hang the link.
module tx_word_scheduler #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 4095
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sched_error
);
  // state | meaning
  // IDLE  | no word outstanding; arbitrate among valid requesters
  // BUSY  | word on tx_data awaiting tx_ack; burst limit or watchdog decides exit

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [BC_W-1:0] BURST_LIMIT = BC_W'(MAX_BURST);
  localparam logic [WD_W-1:0] WDOG_LOAD   = WD_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] PTR_INIT    = ID_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  tx_data_nx;
  logic              tx_valid_nx;
  logic [ID_W-1:0]   grant_nx;
  logic              error_nx;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [BC_W-1:0]   burst_cnt, burst_cnt_nx;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic [NUM_REQ-1:0] ack_raw;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  // Rotating priority: the requester after the last grant is checked first.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx     = state;
    tx_data_nx   = tx_data;
    tx_valid_nx  = tx_valid;
    grant_nx     = grant_id;
    error_nx     = sched_error;
    rr_ptr_nx    = rr_ptr;
    burst_cnt_nx = burst_cnt;
    wdog_nx      = wdog;
    ack_raw      = '0;
    case (state)
      S_IDLE: begin
        if (enable && pick_found) begin
          ack_raw[pick_id] = 1'b1;
          tx_data_nx       = req_data[int'(pick_id)*WIDTH +: WIDTH];
          tx_valid_nx      = 1'b1;
          grant_nx         = pick_id;
          rr_ptr_nx        = pick_id;
          burst_cnt_nx     = BC_W'(1);
          wdog_nx          = WDOG_LOAD;
          state_nx         = S_BUSY;
        end
      end
      S_BUSY: begin
        // An ack arriving in the timeout cycle still counts as a normal completion.
        if (tx_ack) begin
          if (enable && req_valid[grant_id] && (burst_cnt < BURST_LIMIT)) begin
            ack_raw[grant_id] = 1'b1;
            tx_data_nx        = req_data[int'(grant_id)*WIDTH +: WIDTH];
            burst_cnt_nx      = burst_cnt + 1'b1;
            wdog_nx           = WDOG_LOAD;
          end else begin
            tx_valid_nx = 1'b0;
            state_nx    = S_IDLE;
          end
        end else if (wdog == '0) begin
          tx_valid_nx = 1'b0;
          error_nx    = 1'b1;
          state_nx    = S_IDLE;
        end else begin
          wdog_nx = wdog - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Gated so a requester never sees an ack while the block is held in reset.
  assign req_ack = ack_raw & {NUM_REQ{reset_n}};
  assign busy    = (state == S_BUSY);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      grant_id    <= '0;
      sched_error <= 1'b0;
      rr_ptr      <= PTR_INIT;
      burst_cnt   <= '0;
      wdog        <= '0;
    end else begin
      state       <= state_nx;
      tx_data     <= tx_data_nx;
      tx_valid    <= tx_valid_nx;
      grant_id    <= grant_nx;
      sched_error <= error_nx;
      rr_ptr      <= rr_ptr_nx;
      burst_cnt   <= burst_cnt_nx;
      wdog        <= wdog_nx;
    end
  end

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Bench for tx_word_scheduler: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_tx_word_scheduler;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ack;
  logic           busy;
  logic [1:0]     grant_id;
  logic           sched_error;

  tx_word_scheduler #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ack(req_ack), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ack(tx_ack), .busy(busy), .grant_id(grant_id), .sched_error(sched_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] words [N][256];
  int head [N];
  int tail [N];
  bit hold [N];
  bit en_want;
  int ack_mode;     // 0 never, 1 fixed age, 2 random
  int ack_fixed;
  int cur_ack_age;
  logic [N-1:0] ack_seen;
  int cap_log[$];
  int exp_q[$];
  int gap_cnt, valid_cycles;
  bit seen_valid;

  // Reference model: one outstanding word, its owner, how many words this grant
  // has sent, and how many cycles the current word has been on the channel.
  bit m_busy, m_err;
  int m_owner, m_last, m_run, m_age;
  logic [W-1:0] m_word;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += tail[i] - head[i];
    return s;
  endfunction

  function automatic bit done();
    return (pending() == 0) && !m_busy;
  endfunction

  task automatic push(int r, logic [W-1:0] w);
    if (tail[r] < 256) begin
      words[r][tail[r]] = w;
      tail[r]++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_owner = 0; m_last = N - 1;
    m_run = 0; m_age = 0; m_word = '0;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 0;
    end
    cap_log.delete(); exp_q.delete();
    gap_cnt = 0; valid_cycles = 0; seen_valid = 0; cur_ack_age = 0; ack_seen = '0;
  endtask

  task automatic drive_inputs();
    enable = en_want;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i] && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = words[i][head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*W +: W] = W'($urandom);
      end
    end
    if (m_busy && m_age == 1) begin
      if (ack_mode == 0) cur_ack_age = 0;
      else if (ack_mode == 1) cur_ack_age = ack_fixed;
      else if (($urandom % 40) == 0) cur_ack_age = 0;
      else cur_ack_age = int'($urandom_range(1, 5));
    end
    if (m_busy) tx_ack = (cur_ack_age != 0) && (m_age == cur_ack_age);
    else tx_ack = (ack_mode == 2) && (($urandom % 4) == 0);
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ack;
    int g;
    @(negedge clock);
    exp_ack = '0;
    g = -1;
    if (!m_busy) begin
      if (enable)
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
    end else if (tx_ack && enable && req_valid[m_owner] && m_run < MB) begin
      g = m_owner;
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("req_ack", req_ack, exp_ack);
    chk("tx_valid", tx_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_owner);
    chk("sched_error", sched_error, m_err);
    if (m_busy) chk("tx_data", tx_data, m_word);
    ack_seen = req_ack;
    for (int i = 0; i < N; i++) if (req_ack[i]) cap_log.push_back(i);
    if (tx_valid) begin
      seen_valid = 1;
      valid_cycles++;
    end else if (seen_valid && pending() > 0) begin
      gap_cnt++;
    end
    if (g >= 0) begin
      if (!m_busy) begin
        m_run = 0;
        m_last = g;
      end
      m_busy = 1; m_owner = g; m_word = req_data[g*W +: W]; m_run++; m_age = 1;
    end else if (m_busy) begin
      if (tx_ack) m_busy = 0;
      else if (m_age == TO) begin
        m_busy = 0;
        m_err = 1;
      end else m_age++;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (ack_seen[i]) head[i]++;
    drive_inputs();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    clear_bench();
    model_reset();
    drive_inputs();
  endtask

  task automatic run_until_done(int bound, string tag);
    for (int c = 0; c < bound && !done(); c++) cycle();
    chk({tag, "_done"}, done(), 1);
  endtask

  task automatic chk_seq(string tag);
    int mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap_log.size() || cap_log[i] != exp_q[i]) mism++;
    chk({tag, "_len"}, cap_log.size(), exp_q.size());
    chk({tag, "_order"}, mism, 0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; tx_ack = 1'b0; req_valid = 4'b0101; req_data = '0;
    en_want = 1; ack_mode = 1; ack_fixed = 1;
    clear_bench();
    model_reset();
    #12;
    chk("rst_req_ack", req_ack, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_error", sched_error, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    drive_inputs();

    // Single word, ack three cycles after tx_valid rises
    push(2, 16'hA5C3);
    ack_fixed = 4;
    drive_inputs();
    repeat (10) cycle();
    chk("t1_caps", cap_log.size(), 1);
    chk("t1_who", (cap_log.size() > 0) ? cap_log[0] : -1, 2);

    // Fairness with all four requesters loaded
    do_reset();
    for (int r = 0; r < N; r++) for (int i = 0; i < 10; i++) push(r, W'($urandom));
    ack_fixed = 1;
    drive_inputs();
    run_until_done(200, "t2");
    for (int r = 0; r < N; r++) for (int i = 0; i < MB; i++) exp_q.push_back(r);
    for (int r = 0; r < N; r++) for (int i = 0; i < 10 - MB; i++) exp_q.push_back(r);
    chk_seq("t2");

    // Single requester burst of ten words
    do_reset();
    for (int i = 0; i < 10; i++) push(1, W'(16'h1000 + i));
    ack_fixed = 2;
    drive_inputs();
    run_until_done(100, "t3");
    for (int i = 0; i < 10; i++) exp_q.push_back(1);
    chk_seq("t3");
    chk("t3_gap", gap_cnt, 1);

    // Requester 3 arrives mid-burst of requester 0
    do_reset();
    for (int i = 0; i < 12; i++) push(0, W'($urandom));
    push(3, 16'h3333); push(3, 16'h3334);
    hold[3] = 1;
    ack_fixed = 1;
    drive_inputs();
    for (int c = 0; c < 120 && !done(); c++) begin
      cycle();
      if (cap_log.size() >= 3) hold[3] = 0;
    end
    chk("t4_done", done(), 1);
    for (int i = 0; i < MB; i++) exp_q.push_back(0);
    exp_q.push_back(3); exp_q.push_back(3);
    for (int i = 0; i < 4; i++) exp_q.push_back(0);
    chk_seq("t4");

    // Watchdog: no ack ever
    cap_log.delete(); valid_cycles = 0; seen_valid = 0;
    push(2, 16'h0F0F);
    ack_mode = 0;
    drive_inputs();
    repeat (30) cycle();
    chk("t5_valid_len", valid_cycles, TO);
    chk("t5_err", sched_error, 1);
    cap_log.delete(); exp_q.delete();
    ack_mode = 1; ack_fixed = 2;
    push(1, 16'h1234);
    drive_inputs();
    run_until_done(20, "t5b");
    exp_q.push_back(1);
    chk_seq("t5b");
    chk("t5_err_sticky", sched_error, 1);

    // Enable low blocks grants; enable falling mid-burst stops after current word
    cap_log.delete();
    en_want = 0;
    push(2, 16'hC001); push(2, 16'hC002); push(2, 16'hC003);
    drive_inputs();
    repeat (10) cycle();
    chk("t6_no_ack", cap_log.size(), 0);
    en_want = 1; ack_fixed = 3;
    drive_inputs();
    repeat (40) begin
      cycle();
      if (cap_log.size() >= 2) en_want = 0;
    end
    chk("t6_en_drop", cap_log.size(), 2);

    // Reset asserted while busy
    en_want = 1; ack_mode = 0;
    drive_inputs();
    repeat (3) cycle();
    chk("t6_busy_pre", busy, 1);
    chk("t6_grant_pre", grant_id, 2);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_error", sched_error, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_req_ack", req_ack, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    clear_bench();
    model_reset();
    drive_inputs();

    // Randomized traffic
    ack_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (($urandom % 8) == 0) push(i, W'($urandom));
        hold[i] = (($urandom % 5) == 0);
      end
      en_want = (($urandom % 16) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
